// File: rtl/kernel_vect_pkg.sv
// rtl/kernel_vect_pkg.sv - shared mode encoding, lane op and counter sizing for kernel_top_vect
package kernel_vect_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_MUL  = 2'd2,
        MODE_PASS = 2'd3
    } mode_e;

    // Widest lane the shared op supports; callers truncate to their own width.
    localparam int OP_W = 64;

    // Bits needed to hold any value 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // One lane of the kernel; low bits of every result are width-independent.
    function automatic logic [OP_W-1:0] lane_op(input logic [1:0]      m,
                                                input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
        logic [OP_W-1:0] r;
        case (m)
            MODE_ADD: r = a + b;
            MODE_SUB: r = a - b;
            MODE_MUL: r = a * b;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/kernel_vect_fifo.sv
// rtl/kernel_vect_fifo.sv - synchronous first-word-fall-through output FIFO
module kernel_vect_fifo
    import kernel_vect_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd,
    output logic [WIDTH-1:0]           dout,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr, do_rd;

    // Guards keep the pointers sane even if a caller misbehaves.
    assign do_wr = wr & (count_q < CW'(DEPTH));
    assign do_rd = rd & (count_q != '0);

    assign count = count_q;
    assign dout  = (count_q != '0) ? mem[rptr_q] : '0;

    // Storage array: written only, never reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + PW'(1);
            if (do_rd) rptr_q <= rptr_q + PW'(1);
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/kernel_top_vect.sv
// rtl/kernel_top_vect.sv - vectorised lane kernel with non-stalling pipeline and credit-guarded output FIFO
module kernel_top_vect
    import kernel_vect_pkg::*;
#(
    parameter int STREAMW    = 32,
    parameter int NLANES     = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ivalid,
    output logic                        iready,
    input  logic [NLANES*STREAMW-1:0]   vin_a,
    input  logic [NLANES*STREAMW-1:0]   vin_b,
    input  logic [1:0]                  mode,
    output logic                        ovalid,
    input  logic                        oready,
    output logic [NLANES*STREAMW-1:0]   vout,
    output logic [31:0]                 ocount
);

    localparam int W  = NLANES * STREAMW;
    localparam int CW = cnt_w(FIFO_DEPTH);

    if (PIPE_DEPTH < 1) begin : g_bad_pipe
        $error("kernel_top_vect: PIPE_DEPTH must be >= 1");
    end
    if (FIFO_DEPTH < PIPE_DEPTH + 2) begin : g_bad_fifo_size
        $error("kernel_top_vect: FIFO_DEPTH must be >= PIPE_DEPTH+2");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_pow2
        $error("kernel_top_vect: FIFO_DEPTH must be a power of two");
    end
    if (STREAMW > OP_W) begin : g_bad_width
        $error("kernel_top_vect: STREAMW exceeds lane op width");
    end

    logic            rst_q;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   fcount;
    logic [CW:0]     used;
    logic [31:0]     ocount_q, ocount_d;
    logic            accept, pop, wr;
    logic [W-1:0]    res, fifo_dout;

    logic [PIPE_DEPTH-1:0] pv_q;
    logic [W-1:0]          pa_q [PIPE_DEPTH];
    logic [W-1:0]          pb_q [PIPE_DEPTH];
    logic [1:0]            pm_q [PIPE_DEPTH];

    // Credit is computed from registers only so iready has no path from ivalid/oready.
    assign used   = {1'b0, inflight_q} + {1'b0, fcount};
    assign iready = ~rst & ~rst_q & (used < (CW+1)'(FIFO_DEPTH));
    assign accept = ivalid & iready;
    assign ovalid = ~rst & (fcount != '0);
    assign pop    = ovalid & oready;
    assign vout   = ovalid ? fifo_dout : '0;
    assign ocount = rst ? 32'd0 : ocount_q;
    assign wr     = pv_q[PIPE_DEPTH-1];

    // Delayed reset copy holds iready low for the first cycle after release.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Valid shift register: advances every cycle, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                pv_q[s] <= pv_q[s-1];
            end
        end
    end

    // Operand/mode stages: capture on accept, then travel beside their valid bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            pa_q[0] <= vin_a;
            pb_q[0] <= vin_b;
            pm_q[0] <= mode;
        end
        for (int s = 1; s < PIPE_DEPTH; s++) begin
            pa_q[s] <= pa_q[s-1];
            pb_q[s] <= pb_q[s-1];
            pm_q[s] <= pm_q[s-1];
        end
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign res[i*STREAMW +: STREAMW] =
            STREAMW'(lane_op(pm_q[PIPE_DEPTH-1],
                             OP_W'(pa_q[PIPE_DEPTH-1][i*STREAMW +: STREAMW]),
                             OP_W'(pb_q[PIPE_DEPTH-1][i*STREAMW +: STREAMW])));
    end

    // Accept, pipe exit and pop all land in the same update.
    always_comb begin
        inflight_d = inflight_q + CW'(accept) - CW'(wr);
        ocount_d   = ocount_q + 32'(pop);
    end

    // Occupancy and delivered-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            ocount_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            ocount_q   <= ocount_d;
        end
    end

    kernel_vect_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .din   (res),
        .rd    (pop),
        .dout  (fifo_dout),
        .count (fcount)
    );

endmodule

// File: tb/tb_kernel_top_vect.sv
// tb/tb_kernel_top_vect.sv - randomized scoreboard bench for kernel_top_vect
module tb_kernel_top_vect;

    localparam int SW = 32;
    localparam int NL = 2;
    localparam int W  = SW * NL;

    logic          clk = 1'b0;
    logic          rst, ivalid, oready;
    logic          iready, ovalid;
    logic [W-1:0]  vin_a, vin_b, vout;
    logic [1:0]    mode;
    logic [31:0]   ocount;

    int            n_chk = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            n_pop = 0;
    int            mdl_ocount = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  seen[$];

    kernel_top_vect #(
        .STREAMW    (SW),
        .NLANES     (NL),
        .PIPE_DEPTH (3),
        .FIFO_DEPTH (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ivalid (ivalid),
        .iready (iready),
        .vin_a  (vin_a),
        .vin_b  (vin_b),
        .mode   (mode),
        .ovalid (ovalid),
        .oready (oready),
        .vout   (vout),
        .ocount (ocount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int unsigned  x, y, z;
        for (int l = 0; l < NL; l++) begin
            x = a[l*SW +: SW];
            y = b[l*SW +: SW];
            case (m)
                2'd0:    z = x + y;
                2'd1:    z = x - y;
                2'd2:    z = x * y;
                default: z = x;
            endcase
            r[l*SW +: SW] = z;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        vin_a = {$urandom, $urandom};
        vin_b = {$urandom, $urandom};
        mode  = 2'($urandom_range(0, 3));
    endtask

    // Scoreboard: transfers are observed mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_ocount = 0;
        end else begin
            if (ovalid && oready) begin
                if (exp_q.size() == 0) chk("out_spurious", 1, 0);
                else                   chk("vout_order", vout, exp_q.pop_front());
                seen.push_back(vout);
                n_pop++;
                mdl_ocount++;
            end
            if (ivalid && iready) begin
                exp_q.push_back(ref_op(mode, vin_a, vin_b));
                n_acc++;
            end
        end
    end

    initial begin
        int a0, p0;
        rst = 1'b1; ivalid = 1'b1; oready = 1'b0;
        rand_in();

        // Reset held with ivalid high
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("rst_iready", iready, 0);
            chk("rst_ovalid", ovalid, 0);
            chk("rst_vout",   vout,   0);
            chk("rst_ocount", ocount, 0);
            if (c < 3) step();
        end
        rst = 1'b0; ivalid = 1'b0;
        step();
        chk("rel_iready", iready, 1);

        // Single ADD with carry-wrap lane
        vin_a = {32'hFFFF_FFFF, 32'd5};
        vin_b = {32'd1, 32'd7};
        mode = 2'd0; ivalid = 1'b1;
        chk("add_iready", iready, 1);
        step();
        ivalid = 1'b0;
        chk("add_ov_k0", ovalid, 0);
        step(); chk("add_ov_k1", ovalid, 0);
        step(); chk("add_ov_k2", ovalid, 0);
        step(); chk("add_ov_k3", ovalid, 1);
        chk("add_vout", vout, {32'd0, 32'd12});
        oready = 1'b1;
        step();
        oready = 1'b0;
        chk("add_ocount", ocount, 1);
        chk("add_empty", ovalid, 0);

        // Streaming with oready held high
        p0 = n_pop; oready = 1'b1; ivalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_in();
            chk("stream_iready", iready, 1);
            step();
        end
        ivalid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        chk("stream_pops", n_pop - p0, 100);
        chk("stream_ocount", ocount, mdl_ocount);

        // Backpressure: credit must stop at the FIFO depth
        a0 = n_acc; p0 = n_pop; oready = 1'b0; ivalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rand_in();
            step();
        end
        chk("bp_accepts", n_acc - a0, 8);
        chk("bp_iready", iready, 0);
        chk("bp_ovalid", ovalid, 1);
        ivalid = 1'b0; oready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        chk("bp_pops", n_pop - p0, 8);
        chk("bp_left", exp_q.size(), 0);
        chk("bp_ocount", ocount, mdl_ocount);

        // Mode switch mid-stream
        seen.delete(); ivalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                vin_a = {32'd3, 32'h0001_0000};
                vin_b = {32'd4, 32'h0001_0000};
                mode  = 2'd2;
            end else begin
                vin_a = '0;
                vin_b = {32'd1, 32'd1};
                mode  = 2'd1;
            end
            step();
        end
        ivalid = 1'b0;
        for (int c = 0; c < 10; c++) step();
        chk("mode_count", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            if (i < 4) chk("mode_mul", seen[i], {32'd12, 32'd0});
            else       chk("mode_sub", seen[i], {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        end

        // Mid-operation reset: five buffered, two in flight
        oready = 1'b0; ivalid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            rand_in();
            step();
        end
        ivalid = 1'b0;
        step();
        chk("mr_pending", exp_q.size(), 7);
        chk("mr_ovalid_pre", ovalid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_ovalid", ovalid, 0);
        chk("mr_ocount", ocount, 0);
        oready = 1'b1; p0 = n_pop;
        for (int c = 0; c < 8; c++) begin
            chk("mr_quiet", ovalid, 0);
            step();
        end
        chk("mr_nopops", n_pop - p0, 0);
        a0 = n_acc; ivalid = 1'b1;
        for (int c = 0; c < 20 && (n_acc - a0) < 5; c++) begin
            rand_in();
            step();
        end
        ivalid = 1'b0;
        for (int c = 0; c < 10; c++) step();
        chk("mr_new_pops", n_pop - p0, 5);
        chk("mr_new_ocount", ocount, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
